// File: rtl/data_memory.sv
// Single-port word-addressed data memory for the tinyGPU load/store path.
// Registered read (old data on same-address write); async reset restores the i -> i init pattern.
module data_memory #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wren,
    input  logic [15:0]      AR,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] Q
);
    localparam int AW = $clog2(DEPTH);

    typedef logic [DEPTH-1:0][WIDTH-1:0] mem_t;

    function automatic mem_t init_pat();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = WIDTH'(i);
        end
        return m;
    endfunction

    // Declaration initialisers give the same contents at time zero without a reset pulse.
    mem_t             mem = init_pat();
    logic [WIDTH-1:0] q_r = '0;
    logic [AW-1:0]    idx;
    logic             unused_ar;

    assign idx       = AR[AW-1:0];
    assign unused_ar = ^AR[15:AW];
    assign Q         = q_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem <= init_pat();
            q_r <= '0;
        end else begin
            if (wren) mem[idx] <= din;
            q_r <= mem[idx];
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed scenarios plus random traffic against an array model.
module tb_data_memory;
    localparam int DEPTH = 256;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             wren = 1'b0;
    logic [15:0]      AR = '0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] Q;

    int total = 0;
    int bad = 0;
    int model [DEPTH];
    int exp_q [$];
    string name_q [$];

    data_memory #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .wren(wren), .AR(AR), .din(din), .Q(Q)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %04h expected %04h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = i % (1 << WIDTH);
    endtask

    // One access: drive before the edge, queue what Q must show after it.
    task automatic cyc(input bit wr, input int addr, input int data, input string nm);
        int i;
        @(negedge clk);
        wren = wr;
        AR   = 16'(addr);
        din  = WIDTH'(data);
        i = addr % DEPTH;
        exp_q.push_back(model[i]);
        name_q.push_back(nm);
        if (wr) model[i] = data % (1 << WIDTH);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (!reset && exp_q.size() > 0) begin
                check(name_q.pop_front(), int'(Q), exp_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int a, d;
        model_reset();
        // power-on contents without any reset pulse
        for (int i = 0; i < 16; i++) cyc(0, i, 0, "poweron_sweep");

        cyc(1, 5, 'hBEEF, "write5");
        cyc(0, 5, 0, "read5");
        cyc(0, 4, 0, "read4");
        cyc(0, 6, 0, "read6");

        cyc(1, 7, 'h1234, "rdw_old");
        cyc(0, 7, 0, "rdw_new");

        cyc(1, DEPTH + 3, 'hA5A5, "wrap_write");
        cyc(0, 3, 0, "wrap_read");

        for (int i = 0; i < 16; i++) cyc(0, i, 'hFFFF, "wren_low_din");
        for (int i = 0; i < 16; i++) cyc(0, i, 0, "wren_low_read");

        // async reset mid-operation
        cyc(1, 9, 'hBEEF, "pre_reset_write");
        cyc(0, 9, 0, "pre_reset_read");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("reset_async_q", int'(Q), 0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wren = 1'b1;
            AR   = 16'd9;
            din  = 16'hDEAD;
            @(posedge clk);
            #1;
            check("reset_held_q", int'(Q), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        wren  = 1'b0;
        cyc(0, 9, 0, "post_reset9");
        cyc(0, 5, 0, "post_reset5");
        cyc(0, 7, 0, "post_reset7");

        // random traffic, addresses biased into a small window so writes get re-read
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                            : int'($urandom_range(0, 31));
            d = int'($urandom_range(0, 65535));
            cyc($urandom_range(0, 2) == 0, a, d, "random");
        end

        @(negedge clk);
        wren = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
